// File: rtl/tlp_wr2axis.sv
// TLP memory-write sink: grants TLP slots, accepts payload beats and rebuilds a 64-bit AXI4-Stream with SOF/EOF/tlast tags.
// Optional address-window check enabled by defining TLP_WR2AXIS_ADDR_CHECK_EN (adds sticky err_addr output).
module tlp_wr2axis #(
  parameter int MAX_PCIE_PAYLOAD_SIZE = 128,
  parameter int FIFO_DEPTH            = 64
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic [63:0] frame_base_addr,
  input  logic [31:0] frame_size,
  input  logic        tlp_req_to_send,
  output logic        tlp_grant,
  input  logic [6:0]  tlp_fmt_type,
  input  logic [9:0]  tlp_length_in_dw,
  input  logic [63:0] tlp_address,
  input  logic [7:0]  tlp_ldwbe_fdwbe,
  input  logic        tlp_src_rdy_n,
  output logic        tlp_dst_rdy_n,
  input  logic [63:0] tlp_data,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [1:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [31:0] tlp_count,
  output logic        err_fmt
`ifdef TLP_WR2AXIS_ADDR_CHECK_EN
  ,
  output logic        err_addr
`endif
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int RESERVE     = MAX_PCIE_PAYLOAD_SIZE / 8;
  localparam int GRANT_LIMIT = FIFO_DEPTH - RESERVE;
  localparam int WW          = 67;

  localparam logic [6:0] FMT_MWR32 = 7'b1000000;
  localparam logic [6:0] FMT_MWR64 = 7'b1100000;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_HDR, S_DATA, S_DROP} state_t;

  state_t state_reg, state_next;

  logic [9:0]  rem_reg;
  logic [63:0] addr_reg;
  logic [10:0] len_reg;
  logic [7:0]  be_unused_reg;
  logic [31:0] tlp_count_reg;
  logic        err_fmt_reg;

  logic [AW:0]   count_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [WW-1:0] rd_q_reg, byp_reg, head;
  logic          byp_sel_reg;

  logic [10:0] len_dw, nbeats;
  logic [63:0] frame_end, hdr_end, lat_end;
  logic        fmt_ok, addr_ok, hdr_fwd;
  logic        rx_state, full, dst_rdy, xfer, hdr_xfer;
  logic        hdr_last, body_last;
  logic        push, pop, push_sof, push_eof, push_last;
  logic [WW-1:0] push_word;

  // Header decode: a length of zero encodes the maximum 1024 DW.
  always_comb begin
    len_dw    = (tlp_length_in_dw == 10'd0) ? 11'd1024 : {1'b0, tlp_length_in_dw};
    nbeats    = (len_dw + 11'd1) >> 1;
    frame_end = frame_base_addr + {32'b0, frame_size};
    hdr_end   = tlp_address + {51'b0, len_dw, 2'b00};
    lat_end   = addr_reg + {51'b0, len_reg, 2'b00};
    fmt_ok    = (tlp_fmt_type == FMT_MWR32) || (tlp_fmt_type == FMT_MWR64);
`ifdef TLP_WR2AXIS_ADDR_CHECK_EN
    addr_ok   = (tlp_address >= frame_base_addr) && (hdr_end <= frame_end);
`else
    addr_ok   = 1'b1;
`endif
    hdr_fwd   = fmt_ok && addr_ok;
  end

  always_comb begin
    rx_state  = (state_reg == S_HDR) || (state_reg == S_DATA) || (state_reg == S_DROP);
    full      = (count_reg == FIFO_DEPTH[AW:0]);
    dst_rdy   = rx_state && !full;
    xfer      = dst_rdy && !tlp_src_rdy_n;
    hdr_xfer  = xfer && (state_reg == S_HDR);
    hdr_last  = (nbeats == 11'd1);
    body_last = (rem_reg == 10'd1);
    push      = (hdr_xfer && hdr_fwd) || (xfer && (state_reg == S_DATA));
    push_sof  = (state_reg == S_HDR) && (tlp_address == frame_base_addr);
    push_last = (state_reg == S_HDR) ? hdr_last : body_last;
    push_eof  = push_last &&
                ((state_reg == S_HDR) ? (hdr_end == frame_end) : (lat_end == frame_end));
    push_word = {push_last, push_eof, push_sof, tlp_data};
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) state_reg <= S_IDLE;
    else              state_reg <= state_next;
  end

  // Grant only when a full max-size payload is guaranteed to fit in the FIFO.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (tlp_req_to_send && (count_reg <= GRANT_LIMIT[AW:0])) state_next = S_GRANT;
      S_GRANT: state_next = S_HDR;
      S_HDR: begin
        if (xfer) begin
          if (hdr_last)     state_next = S_IDLE;
          else if (hdr_fwd) state_next = S_DATA;
          else              state_next = S_DROP;
        end
      end
      S_DATA, S_DROP: if (xfer && body_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tlp_grant     = (state_reg == S_GRANT);
    tlp_dst_rdy_n = !dst_rdy;
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      rem_reg       <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      be_unused_reg <= '0;
      tlp_count_reg <= '0;
      err_fmt_reg   <= 1'b0;
    end else begin
      if (hdr_xfer) begin
        addr_reg      <= tlp_address;
        len_reg       <= len_dw;
        be_unused_reg <= tlp_ldwbe_fdwbe;
        rem_reg       <= nbeats[9:0] - 10'd1;
      end else if (xfer) begin
        rem_reg <= rem_reg - 10'd1;
      end
      if (push && push_last) tlp_count_reg <= tlp_count_reg + 32'd1;
      if (hdr_xfer && !fmt_ok) err_fmt_reg <= 1'b1;
    end
  end

`ifdef TLP_WR2AXIS_ADDR_CHECK_EN
  logic err_addr_reg;

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n)                        err_addr_reg <= 1'b0;
    else if (hdr_xfer && fmt_ok && !addr_ok) err_addr_reg <= 1'b1;
  end

  assign err_addr = err_addr_reg;
`endif

  assign tlp_count = tlp_count_reg;
  assign err_fmt   = err_fmt_reg;

  // FWFT FIFO over a registered-read RAM; a bypass register covers a write to the next read slot.
  assign pop         = m_axis_tvalid && m_axis_tready;
  assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge axi_clk) begin
    rd_q_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      byp_reg     <= '0;
      byp_sel_reg <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      byp_reg     <= push_word;
      byp_sel_reg <= push && (wr_ptr_reg == rd_ptr_next);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head          = byp_sel_reg ? byp_reg : rd_q_reg;
  assign m_axis_tvalid = (count_reg != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[63:0]  : 64'd0;
  assign m_axis_tuser  = m_axis_tvalid ? head[65:64] : 2'd0;
  assign m_axis_tlast  = m_axis_tvalid ? head[66]    : 1'b0;

endmodule

// File: tb/tb_tlp_wr2axis.sv
// Scoreboard bench for tlp_wr2axis: a TLP transmitter model pushes expected beats, a monitor pops and compares stream output.
module tb_tlp_wr2axis;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic [63:0] frame_base_addr = 64'h1000;
  logic [31:0] frame_size = 32'd800;
  logic        tlp_req_to_send = 1'b0;
  logic        tlp_grant;
  logic [6:0]  tlp_fmt_type = 7'd0;
  logic [9:0]  tlp_length_in_dw = 10'd0;
  logic [63:0] tlp_address = 64'd0;
  logic [7:0]  tlp_ldwbe_fdwbe = 8'd0;
  logic        tlp_src_rdy_n = 1'b1;
  logic        tlp_dst_rdy_n;
  logic [63:0] tlp_data = 64'd0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic [31:0] tlp_count;
  logic        err_fmt;
`ifdef TLP_WR2AXIS_ADDR_CHECK_EN
  logic        err_addr;
`endif

  localparam logic [6:0] MWR32 = 7'b1000000;
  localparam logic [6:0] MWR64 = 7'b1100000;
  localparam logic [6:0] MRD   = 7'b0000000;

  tlp_wr2axis #(.MAX_PCIE_PAYLOAD_SIZE(128), .FIFO_DEPTH(64)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .frame_base_addr(frame_base_addr), .frame_size(frame_size),
    .tlp_req_to_send(tlp_req_to_send), .tlp_grant(tlp_grant),
    .tlp_fmt_type(tlp_fmt_type), .tlp_length_in_dw(tlp_length_in_dw),
    .tlp_address(tlp_address), .tlp_ldwbe_fdwbe(tlp_ldwbe_fdwbe),
    .tlp_src_rdy_n(tlp_src_rdy_n), .tlp_dst_rdy_n(tlp_dst_rdy_n),
    .tlp_data(tlp_data), .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .tlp_count(tlp_count), .err_fmt(err_fmt)
`ifdef TLP_WR2AXIS_ADDR_CHECK_EN
    , .err_addr(err_addr)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct packed {
    logic        last;
    logic [1:0]  user;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_exp;
  int n_cmp = 0;
  int n_bad = 0;
  int occ = 0;
  int grant_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each stream handshake; also checks the free space at every grant.
  always @(negedge axi_clk) begin
    if (axi_reset_n && m_axis_tvalid && m_axis_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: actual data=%0h user=%0b last=%0b required=no output",
                 m_axis_tdata, m_axis_tuser, m_axis_tlast);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tuser, m_axis_tdata} !== mon_exp) begin
          n_bad++;
          $display("FAIL stream_beat: actual data=%0h user=%0b last=%0b required data=%0h user=%0b last=%0b",
                   m_axis_tdata, m_axis_tuser, m_axis_tlast, mon_exp.data, mon_exp.user, mon_exp.last);
        end else begin
          $display("OUT  data=%0h user=%0b last=%0b", m_axis_tdata, m_axis_tuser, m_axis_tlast);
        end
      end
      occ--;
    end
    if (axi_reset_n && tlp_grant) begin
      grant_cnt++;
      n_cmp++;
      if (64 - occ < 16) begin
        n_bad++;
        $display("FAIL grant_free_space: actual free=%0d required>=16", 64 - occ);
      end
    end
  end

  task automatic send_tlp(input logic [6:0] fmt, input logic [9:0] len, input logic [63:0] addr,
                          input logic [63:0] d0, input bit sof, input bit eof, input bit fwd,
                          input int stop_after);
    int lenv;
    int nb;
    int wc;
    int sent;
    bit ok;
    beat_t e;
    lenv = (len == 10'd0) ? 1024 : int'(len);
    nb   = (lenv + 1) / 2;
    sent = 0;
    tlp_req_to_send = 1'b1;
    wc = 0;
    do begin @(negedge axi_clk); ok = tlp_grant; wc++; end while (!ok && wc < 4000);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: actual=no grant required=grant addr=%0h", addr);
      tlp_req_to_send = 1'b0;
      return;
    end
    @(posedge axi_clk); #1;
    tlp_req_to_send  = 1'b0;
    tlp_fmt_type     = fmt;
    tlp_length_in_dw = len;
    tlp_address      = addr;
    tlp_ldwbe_fdwbe  = 8'hFF;
    for (int b = 0; b < nb; b++) begin
      if (stop_after >= 0 && b >= stop_after) break;
      tlp_data      = d0 + 64'(b);
      tlp_src_rdy_n = 1'b0;
      wc = 0;
      do begin @(negedge axi_clk); ok = !tlp_dst_rdy_n; wc++; end while (!ok && wc < 4000);
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_timeout: actual=not ready required=ready beat=%0d", b);
        tlp_src_rdy_n = 1'b1;
        return;
      end
      if (fwd) begin
        e.data = d0 + 64'(b);
        e.user = {eof && (b == nb - 1), sof && (b == 0)};
        e.last = (b == nb - 1);
        exp_q.push_back(e);
        occ++;
      end
      sent++;
      @(posedge axi_clk); #1;
    end
    tlp_src_rdy_n = 1'b1;
    $display("TLP  fmt=%0b len=%0d addr=%0h beats=%0d", fmt, len, addr, sent);
  endtask

  task automatic wait_empty(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && c < 3000) begin @(negedge axi_clk); c++; end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_tdata"}, m_axis_tdata, 64'd0);
    check({tag, "_tuser"}, m_axis_tuser, 2'd0);
    check({tag, "_tlast"}, m_axis_tlast, 1'b0);
    check({tag, "_grant"}, tlp_grant, 1'b0);
    check({tag, "_dst_rdy_n"}, tlp_dst_rdy_n, 1'b1);
    check({tag, "_tlp_count"}, tlp_count, 32'd0);
    check({tag, "_err_fmt"}, err_fmt, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    check_reset_outputs("reset");
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;

    // 100-beat frame: 6 TLPs of 32 DW plus one of 8 DW.
    for (int i = 0; i < 7; i++)
      send_tlp(MWR64, (i < 6) ? 10'd32 : 10'd8, 64'h1000 + 64'(128 * i), 64'(16 * i),
               i == 0, i == 6, 1'b1, -1);
    wait_empty("frame_drain");
    check("frame_tlp_count", tlp_count, 32'd7);

    // Same frame with the sink stalled: only four TLPs fit before grants stop.
    @(posedge axi_clk); #1;
    m_axis_tready = 1'b0;
    grant_cnt = 0;
    fork
      for (int i = 0; i < 7; i++)
        send_tlp(MWR64, (i < 6) ? 10'd32 : 10'd8, 64'h1000 + 64'(128 * i), 64'(16 * i),
                 i == 0, i == 6, 1'b1, -1);
      begin
        repeat (300) @(posedge axi_clk);
        @(negedge axi_clk);
        check("stall_grants", 64'(grant_cnt), 64'd4);
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_dst_rdy_n", tlp_dst_rdy_n, 1'b1);
        @(posedge axi_clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_empty("stall_drain");
    check("stall_tlp_count", tlp_count, 32'd14);

    // Memory read: drained and discarded.
    send_tlp(MRD, 10'd4, 64'h1000, 64'h0, 1'b0, 1'b0, 1'b0, -1);
    repeat (5) @(posedge axi_clk);
    @(negedge axi_clk);
    check("mrd_err_fmt", err_fmt, 1'b1);
    check("mrd_tlp_count", tlp_count, 32'd14);
    check("mrd_tvalid", m_axis_tvalid, 1'b0);

    // Odd length: 3 DW frame of 12 bytes.
    frame_size = 32'd12;
    send_tlp(MWR32, 10'd3, 64'h1000, 64'hDEADBEEF_00000001, 1'b1, 1'b1, 1'b1, -1);
    wait_empty("odd_drain");
    check("odd_tlp_count", tlp_count, 32'd15);

    // Single-beat TLP covering a whole 8-byte frame.
    frame_size = 32'd8;
    send_tlp(MWR32, 10'd2, 64'h1000, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b1, -1);
    wait_empty("single_drain");
    check("single_tlp_count", tlp_count, 32'd16);

    // Length field 0 means 1024 DW (512 beats).
    frame_size = 32'd4096;
    send_tlp(MWR64, 10'd0, 64'h1000, 64'h5000, 1'b1, 1'b1, 1'b1, -1);
    send_tlp(MWR64, 10'd4, 64'h2000, 64'h6000, 1'b0, 1'b0, 1'b1, -1);
    wait_empty("max_len_drain");
    check("max_len_tlp_count", tlp_count, 32'd18);

    // Reset in the middle of a TLP.
    frame_size = 32'd800;
    @(posedge axi_clk); #1;
    m_axis_tready = 1'b0;
    send_tlp(MWR64, 10'd32, 64'h1000, 64'h500, 1'b1, 1'b0, 1'b1, 5);
    axi_reset_n = 1'b0;
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;
    exp_q.delete();
    occ = 0;
    @(negedge axi_clk);
    check_reset_outputs("midreset");
    @(posedge axi_clk); #1;
    m_axis_tready = 1'b1;
    send_tlp(MWR64, 10'd8, 64'h1000, 64'h700, 1'b1, 1'b0, 1'b1, -1);
    wait_empty("post_reset_drain");
    check("post_reset_tlp_count", tlp_count, 32'd1);

`ifdef TLP_WR2AXIS_ADDR_CHECK_EN
    check("addr_err_initial", err_addr, 1'b0);
    send_tlp(MWR64, 10'd4, 64'h0800, 64'h900, 1'b0, 1'b0, 1'b0, -1);
    repeat (5) @(posedge axi_clk);
    @(negedge axi_clk);
    check("addr_err_set", err_addr, 1'b1);
    check("addr_err_tlp_count", tlp_count, 32'd1);
    check("addr_err_tvalid", m_axis_tvalid, 1'b0);
`endif

    repeat (5) @(posedge axi_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
